dac_spi_tx: RTL and testbench

Downstream output stage for the IIR filter. Accepts filtered 8-bit samples on a valid/ready handshake, buffers them, and serialises each into a 16-bit SPI mode-0 frame for an external serial DAC. Replaces direct parallel drive of the DAC. Flags and counts samples dropped when the filter outpaces the DAC link.

---
 rtl/dac_spi_pkg.sv | 8 +
 rtl/dac_spi_fifo.sv | 48 ++++
 rtl/dac_spi_tx.sv | 141 ++++++++++++++
 tb/tb_dac_spi_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared FSM states, frame geometry and default command nibble for dac_spi_tx
package dac_spi_pkg;
    typedef enum logic [2:0] {IDLE, LOW, HIGH, TRAIL, GAP} state_t;
    localparam int FRAME_W = 16;
    localparam int DATA_W = 8;
    localparam int PAD_W = 4;
    localparam logic [3:0] CTRL_DEFAULT = 4'b0011;
endpackage

// File: rtl/dac_spi_fifo.sv
// dac_spi_fifo: synchronous sample FIFO with registered full/empty and wrap-bit pointers
module dac_spi_fifo
    import dac_spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_afull
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr, r_rptr, w_wptr, w_rptr;
    logic              r_full, r_empty, w_push, w_pop;
    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && !r_empty;
    assign w_wptr  = r_wptr + (AW+1)'(w_push);
    assign w_rptr  = r_rptr + (AW+1)'(w_pop);
    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    // one slot left: a push alone would fill the FIFO
    assign o_afull = (r_wptr - r_rptr) == (AW+1)'(DEPTH - 1);
    // pointers advance and flags are precomputed from next-pointer values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr;
            r_rptr  <= w_rptr;
            r_full  <= (w_wptr[AW] != w_rptr[AW]) && (w_wptr[AW-1:0] == w_rptr[AW-1:0]);
            r_empty <= w_wptr == w_rptr;
        end
    end
    // sample storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: buffers 8-bit samples and shifts them out as 16-bit SPI mode-0 DAC frames; DAC_SPI_FIFO_EN selects a FIFO buffer instead of one holding register
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [3:0] CTRL_BITS  = CTRL_DEFAULT,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        ovf_clr,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  drop_cnt
);
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    state_t              r_state, w_next;
    logic [7:0]          r_cnt, r_drop;
    logic [3:0]          r_bit;
    logic [FRAME_W-1:0]  r_sh;
    logic [DATA_W-1:0]   w_data;
    logic r_ready, r_ovf, r_cs_n, r_sclk, r_mosi, r_busy;
    logic w_push, w_drop, w_pop, w_empty, w_full, w_afull, w_done, w_shift;
    assign w_push  = din_valid && r_ready;
    assign w_drop  = din_valid && !r_ready;
    assign w_done  = r_cnt == 8'd0;
    assign w_shift = (r_state == HIGH) && (w_next == LOW);
`ifdef DAC_SPI_FIFO_EN
    dac_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (din),
        .o_data  (w_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_afull (w_afull)
    );
`else
    logic [DATA_W-1:0] r_hold;
    logic              r_hfull;
    assign w_data  = r_hold;
    assign w_full  = r_hfull;
    assign w_empty = !r_hfull;
    assign w_afull = !r_hfull;
    // single-sample holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_hfull <= 1'b0;
        end else begin
            if (w_push) r_hold <= din;
            r_hfull <= w_push || (r_hfull && !w_pop);
        end
    end
`endif
    // ready ignores a same-cycle pop, so a full buffer never admits a push on the pop cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ready <= 1'b1;
        else        r_ready <= !(w_full || (w_push && w_afull));
    end
    // sticky overflow flag and saturating drop counter, clear wins over drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (ovf_clr) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf  <= 1'b1;
            r_drop <= (r_drop == 8'hFF) ? r_drop : r_drop + 8'd1;
        end
    end
    // FSM next state and pop decision
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop  = !w_empty;
                w_next = w_empty ? IDLE : LOW;
            end
            LOW:     w_next = w_done ? HIGH : LOW;
            HIGH:    w_next = !w_done ? HIGH : (r_bit == 4'(FRAME_W - 1)) ? TRAIL : LOW;
            TRAIL:   w_next = w_done ? GAP : TRAIL;
            GAP:     w_next = w_done ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // divider reloads on every state entry; shift register and bit index follow SCLK falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_sh  <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? DIV_M1 : r_cnt - 8'd1;
            if (w_pop) begin
                r_sh  <= {CTRL_BITS, w_data, {PAD_W{1'b0}}};
                r_bit <= '0;
            end else if (w_shift) begin
                r_sh  <= {r_sh[FRAME_W-2:0], 1'b0};
                r_bit <= r_bit + 4'd1;
            end
        end
    end
    // registered pin drive decoded from the current state; mosi only updates in LOW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_n <= 1'b1;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cs_n <= (r_state == IDLE) || (r_state == GAP);
            r_sclk <= r_state == HIGH;
            r_mosi <= (r_state == LOW) ? r_sh[FRAME_W-1] : r_mosi;
            r_busy <= r_state != IDLE;
        end
    end
    assign din_ready = r_ready;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop;
    assign dac_cs_n  = r_cs_n;
    assign dac_sclk  = r_sclk;
    assign dac_mosi  = r_mosi;
    assign busy      = r_busy;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx; expected frames queued at stimulus, checked by a pin-level SPI monitor
module tb_dac_spi_tx;
    localparam int         DIV  = 4;
    localparam logic [3:0] CTRL = 4'b0011;
`ifdef DAC_SPI_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, ovf_clr = 1'b0;
    logic [7:0] din = '0;
    logic din_ready, dac_cs_n, dac_sclk, dac_mosi, busy, ovf;
    logic [7:0] drop_cnt;
    int n_vec = 0, n_err = 0;
    logic [15:0] exp_q [$];
    logic active = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] bits;
    int nbits, low_cnt;

    dac_spi_tx #(.CLK_DIV(DIV), .CTRL_BITS(CTRL), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .ovf_clr(ovf_clr), .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi),
        .busy(busy), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] d);
        return {CTRL, d, 4'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy && dac_cs_n) break;
            tick();
        end
        check("idle_queue", exp_q.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    // SPI monitor: captures mosi on SCLK rises, measures cs_n low time, scores each frame
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) active = 1'b0;
        else begin
            if (prev_cs && !dac_cs_n) begin
                active = 1'b1;
                bits = '0;
                nbits = 0;
                low_cnt = 0;
            end
            if (active) begin
                if (!dac_cs_n) low_cnt++;
                if (!prev_sclk && dac_sclk) begin
                    bits = {bits[14:0], dac_mosi};
                    nbits++;
                end
                if (dac_cs_n) begin
                    e = exp_q.size() != 0 ? {16'h0, exp_q.pop_front()} : 32'h1_0000;
                    check("frame", {16'h0, bits}, e);
                    check("sclk_rises", nbits, 16);
                    check("cs_low_cycles", low_cnt, 33 * DIV);
                    active = 1'b0;
                end
            end
        end
        prev_cs = dac_cs_n;
        prev_sclk = dac_sclk;
    end

    initial begin
        int n_acc, rises, falls;
        logic ps, pc;
        repeat (3) tick();
        check("rst_cs_n", dac_cs_n, 1);
        check("rst_sclk", dac_sclk, 0);
        check("rst_mosi", dac_mosi, 0);
        check("rst_ready", din_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        din = 8'hA5;
        din_valid = 1'b1;
        exp_q.push_back(frame_of(8'hA5));
        tick();
        din_valid = 1'b0;
        check("lat_n_cs", dac_cs_n, 1);
        check("lat_n_ready", din_ready, FIFO);
        tick();
        check("lat_n1_cs", dac_cs_n, 1);
        tick();
        check("lat_n2_cs", dac_cs_n, 0);
        check("lat_n2_busy", busy, 1);
        wait_idle();
        check("single_drop", drop_cnt, 0);
        check("single_ovf", ovf, 0);
        n_acc = FIFO ? 5 : 1;
        for (int i = 0; i < (FIFO ? 6 : 3); i++) begin
            din = 8'(i + 1);
            din_valid = 1'b1;
            if (i < n_acc) exp_q.push_back(frame_of(8'(i + 1)));
            tick();
        end
        din_valid = 1'b0;
        wait_idle();
        check("ovf_drop_cnt", drop_cnt, FIFO ? 1 : 2);
        check("ovf_flag", ovf, 1);
        for (int i = 0; i < n_acc; i++) begin
            din = 8'(8'h40 + i);
            din_valid = 1'b1;
            exp_q.push_back(frame_of(8'(8'h40 + i)));
            tick();
        end
        din = 8'h7F;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_drop", drop_cnt, 0);
        tick();
        din_valid = 1'b0;
        check("post_clr_drop", drop_cnt, 1);
        check("post_clr_ovf", ovf, 1);
        wait_idle();
        din = 8'h77;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        rises = 0;
        ps = dac_sclk;
        for (int i = 0; i < 500 && rises < 5; i++) begin
            tick();
            if (!ps && dac_sclk) rises++;
            ps = dac_sclk;
        end
        check("abort_rises", rises, 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", dac_cs_n, 1);
        check("abort_sclk", dac_sclk, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("abort_ready", din_ready, 1);
        check("abort_busy", busy, 0);
        falls = 0;
        pc = dac_cs_n;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pc && !dac_cs_n) falls++;
            pc = dac_cs_n;
        end
        check("abort_no_frame", falls, 0);
        check("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
